// File: rtl/vx_tcu_drl_exp_align_pkg.sv
// Shared types and constants for the TCU exponent-alignment stage.
// EXP_NEG_INF marks a zero term; tcu_align_t is the stage-2 output bundle.
package vx_tcu_drl_exp_align_pkg;

    localparam int N_D       = 2;
    localparam int TCK_D     = 2 * N_D;
    localparam int WA_D      = 28;
    localparam int EXP_W_D   = 10;
    localparam int TAG_W_D   = 8;
    localparam int SHIFT_W_D = $clog2(WA_D + 1);

    localparam logic [EXP_W_D-1:0] EXP_NEG_INF = {1'b1, {(EXP_W_D-1){1'b0}}};

    function automatic logic is_neg_inf(input logic [EXP_W_D-1:0] e);
        return e == EXP_NEG_INF;
    endfunction

    typedef struct packed {
        logic [EXP_W_D-1:0]                max_exp;
        logic [TCK_D:0][SHIFT_W_D-1:0]     shift_amt;
        logic [TCK_D:0]                    zero_mask;
        logic                              all_zero;
    } tcu_align_t;

endpackage

// File: rtl/vx_tcu_drl_exp_align_if.sv
// Valid/ready bundle for the exponent-alignment stage.
// master drives the input beat and ready_out; slave is the aligner itself.
interface vx_tcu_drl_exp_align_if
    import vx_tcu_drl_exp_align_pkg::*;
#(
    parameter int N       = N_D,
    parameter int TCK     = 2 * N,
    parameter int WA      = WA_D,
    parameter int EXP_W   = EXP_W_D,
    parameter int TAG_W   = TAG_W_D,
    parameter int SHIFT_W = $clog2(WA + 1)
);
    logic                       valid_in;
    logic                       ready_in;
    logic [TCK:0][EXP_W-1:0]    raw_exp_in;
    logic [TAG_W-1:0]           tag_in;
    logic                       valid_out;
    logic                       ready_out;
    logic [EXP_W-1:0]           max_exp;
    logic [TCK:0][SHIFT_W-1:0]  shift_amt;
    logic [TCK:0]               zero_mask;
    logic                       all_zero;
    logic [TAG_W-1:0]           tag_out;

    modport master (
        output valid_in, raw_exp_in, tag_in, ready_out,
        input  ready_in, valid_out, max_exp, shift_amt,
        input  zero_mask, all_zero, tag_out
    );

    modport slave (
        input  valid_in, raw_exp_in, tag_in, ready_out,
        output ready_in, valid_out, max_exp, shift_amt,
        output zero_mask, all_zero, tag_out
    );
endinterface

// File: rtl/vx_tcu_drl_exp_align_max_tree.sv
// Combinational balanced signed-max reduction over N_OPS operands.
// Recursively splits the operand vector in half; depth is ceil(log2(N_OPS)).
module vx_tcu_drl_exp_align_max_tree
    import vx_tcu_drl_exp_align_pkg::*;
#(
    parameter int N_OPS = TCK_D + 1,
    parameter int W     = EXP_W_D
) (
    input  logic [N_OPS-1:0][W-1:0] i_ops,
    output logic [W-1:0]            o_max
);
    generate
        if (N_OPS == 1) begin : g_leaf
            assign o_max = i_ops[0];
        end else begin : g_node
            localparam int LO = N_OPS / 2;
            localparam int HI = N_OPS - LO;
            logic [W-1:0] w_lo;
            logic [W-1:0] w_hi;

            vx_tcu_drl_exp_align_max_tree #(.N_OPS(LO), .W(W)) u_lo (
                .i_ops (i_ops[LO-1:0]),
                .o_max (w_lo)
            );

            vx_tcu_drl_exp_align_max_tree #(.N_OPS(HI), .W(W)) u_hi (
                .i_ops (i_ops[N_OPS-1:LO]),
                .o_max (w_hi)
            );

            assign o_max = ($signed(w_hi) > $signed(w_lo)) ? w_hi : w_lo;
        end
    endgenerate
endmodule

// File: rtl/vx_tcu_drl_exp_align.sv
// Two-stage elastic exponent aligner: max tree, then subtract-and-saturate.
// Optional TCU_ALIGN_PERF_EN adds perf_beats / perf_sat_terms counters.
module vx_tcu_drl_exp_align
    import vx_tcu_drl_exp_align_pkg::*;
#(
    parameter int N       = N_D,
    parameter int TCK     = 2 * N,
    parameter int WA      = WA_D,
    parameter int EXP_W   = EXP_W_D,
    parameter int TAG_W   = TAG_W_D,
    parameter int SHIFT_W = $clog2(WA + 1)
) (
    input  logic clk,
    input  logic reset,
    vx_tcu_drl_exp_align_if.slave bus
`ifdef TCU_ALIGN_PERF_EN
    ,
    output logic [31:0] perf_beats,
    output logic [31:0] perf_sat_terms
`endif
);
    localparam logic [EXP_W:0]   DIFF_SAT  = (EXP_W+1)'(WA);
    localparam logic [SHIFT_W-1:0] SHIFT_SAT = SHIFT_W'(WA);

    logic                      r_v1;
    logic                      r_v2;
    logic [EXP_W-1:0]          r_max1;
    logic [TCK:0][EXP_W-1:0]   r_exp1;
    logic [TAG_W-1:0]          r_tag1;
    logic [TAG_W-1:0]          r_tag2;
    tcu_align_t                r_out;

    logic                      w_ready;
    logic                      w_adv1;
    logic                      w_adv2;
    logic [EXP_W-1:0]          w_max;
    logic [TCK:0][EXP_W:0]     w_diff;
    tcu_align_t                w_out;

    assign w_ready = !r_v1 || !r_v2 || bus.ready_out;
    assign w_adv1  = bus.valid_in && w_ready;
    assign w_adv2  = r_v1 && (!r_v2 || bus.ready_out);

    vx_tcu_drl_exp_align_max_tree #(.N_OPS(TCK+1), .W(EXP_W)) u_max (
        .i_ops (bus.raw_exp_in),
        .o_max (w_max)
    );

    // diff is taken in EXP_W+1 bits so a full-range spread cannot wrap
    always_comb begin
        w_out  = '0;
        w_diff = '0;
        w_out.max_exp = r_max1;
        for (int i = 0; i <= TCK; i++) begin
            w_diff[i] = {r_max1[EXP_W-1], r_max1}
                      - {r_exp1[i][EXP_W-1], r_exp1[i]};
            if (is_neg_inf(r_exp1[i])) begin
                w_out.shift_amt[i] = SHIFT_SAT;
                w_out.zero_mask[i] = 1'b1;
            end else if (w_diff[i] >= DIFF_SAT) begin
                w_out.shift_amt[i] = SHIFT_SAT;
            end else begin
                w_out.shift_amt[i] = w_diff[i][SHIFT_W-1:0];
            end
        end
        w_out.all_zero = &w_out.zero_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_max1 <= '0;
            r_exp1 <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_out  <= '0;
        end else begin
            if (w_adv1) begin
                r_v1   <= 1'b1;
                r_max1 <= w_max;
                r_exp1 <= bus.raw_exp_in;
                r_tag1 <= bus.tag_in;
            end else if (w_adv2) begin
                r_v1   <= 1'b0;
            end
            if (w_adv2) begin
                r_v2   <= 1'b1;
                r_out  <= w_out;
                r_tag2 <= r_tag1;
            end else if (bus.ready_out) begin
                r_v2   <= 1'b0;
            end
        end
    end

    assign bus.ready_in  = w_ready;
    assign bus.valid_out = r_v2;
    assign bus.max_exp   = r_out.max_exp;
    assign bus.shift_amt = r_out.shift_amt;
    assign bus.zero_mask = r_out.zero_mask;
    assign bus.all_zero  = r_out.all_zero;
    assign bus.tag_out   = r_tag2;

`ifdef TCU_ALIGN_PERF_EN
    logic [31:0] r_beats;
    logic [31:0] r_sat;
    logic [31:0] w_sat_cnt;

    always_comb begin
        w_sat_cnt = '0;
        for (int i = 0; i <= TCK; i++) begin
            if (!r_out.zero_mask[i] && r_out.shift_amt[i] == SHIFT_SAT)
                w_sat_cnt = w_sat_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_beats <= '0;
            r_sat   <= '0;
        end else if (r_v2 && bus.ready_out) begin
            r_beats <= r_beats + 32'd1;
            r_sat   <= r_sat + w_sat_cnt;
        end
    end

    assign perf_beats     = r_beats;
    assign perf_sat_terms = r_sat;
`endif
endmodule

// File: tb/tb_vx_tcu_drl_exp_align.sv
// Self-checking bench for vx_tcu_drl_exp_align: directed cases plus random
// traffic scored against a behavioural queue model.
module tb_vx_tcu_drl_exp_align;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    vx_tcu_drl_exp_align_if bus ();

`ifdef TCU_ALIGN_PERF_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_sat_terms;
`endif

    vx_tcu_drl_exp_align dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef TCU_ALIGN_PERF_EN
        ,
        .perf_beats     (perf_beats),
        .perf_sat_terms (perf_sat_terms)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {tag, max_exp, shift_amt[4:0], zero_mask, all_zero}
    function automatic logic [48:0] ref_beat(input logic [4:0][9:0] e,
                                             input logic [7:0] t);
        int m;
        int v;
        logic [24:0] sh;
        logic [4:0]  zm;
        logic [9:0]  mx;
        m  = -512;
        sh = '0;
        zm = '0;
        for (int i = 0; i < 5; i++) begin
            v = int'($signed(e[i]));
            if (v > m) m = v;
        end
        for (int i = 0; i < 5; i++) begin
            v = int'($signed(e[i]));
            if (v == -512) begin
                zm[i] = 1'b1;
                sh[i*5 +: 5] = 5'd28;
            end else if (m - v >= 28) begin
                sh[i*5 +: 5] = 5'd28;
            end else begin
                sh[i*5 +: 5] = 5'(m - v);
            end
        end
        mx = 10'(m);
        return {t, mx, sh, zm, &zm};
    endfunction

    logic [48:0] q[$];
    logic [48:0] w_obs;
    assign w_obs = {bus.tag_out, bus.max_exp, bus.shift_amt,
                    bus.zero_mask, bus.all_zero};

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            if (bus.valid_out) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(bus.valid_out), 64'd0);
                end else begin
                    chk("beat", 64'(w_obs), 64'(q[0]));
                    if (bus.ready_out) void'(q.pop_front());
                end
            end
            if (bus.valid_in && bus.ready_in)
                q.push_back(ref_beat(bus.raw_exp_in, bus.tag_in));
        end
    end

    task automatic send_lat(input string nm, input logic [4:0][9:0] e,
                            input logic [7:0] t, input logic [9:0] emax,
                            input logic [4:0] ezm, input logic eaz);
        @(posedge clk); #1;
        chk({nm, "_rdy"}, 64'(bus.ready_in), 64'd1);
        bus.valid_in   = 1'b1;
        bus.raw_exp_in = e;
        bus.tag_in     = t;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk({nm, "_early"}, 64'(bus.valid_out), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_lat"}, 64'(bus.valid_out), 64'd1);
        chk({nm, "_max"}, 64'(bus.max_exp), 64'(emax));
        chk({nm, "_zm"}, 64'(bus.zero_mask), 64'(ezm));
        chk({nm, "_az"}, 64'(bus.all_zero), 64'(eaz));
    endtask

    function automatic logic [9:0] rnd_exp(input int base);
        int r;
        r = int'($urandom % 8);
        if (r == 0) return 10'h200;
        if (r == 1) return 10'($urandom);
        return 10'(base + int'($urandom % 40));
    endfunction

    initial begin
        int k;
        int guard;
        int base;
        logic acc;
        logic [7:0] tg;
        bus.valid_in   = 1'b0;
        bus.raw_exp_in = '0;
        bus.tag_in     = '0;
        bus.ready_out  = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_payload", 64'(w_obs), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_in", 64'(bus.ready_in), 64'd1);

        send_lat("basic", {10'd130, 10'd120, 10'd125, 10'd100, 10'd140},
                 8'h11, 10'd140, 5'b00000, 1'b0);
        send_lat("zero", {10'h200, 10'd50, 10'h200, 10'd60, 10'd60},
                 8'h22, 10'd60, 5'b10100, 1'b0);
        send_lat("allz", {5{10'h200}}, 8'h33, 10'h200, 5'b11111, 1'b1);
        send_lat("signed", {10'h3FB, 10'h3FD, 10'h3F6, 10'h3FD, 10'h3EC},
                 8'h44, 10'h3FD, 5'b00000, 1'b0);
        send_lat("spread", {10'h1FF, 10'h201, 10'd0, 10'd484, 10'd511},
                 8'h55, 10'd511, 5'b00000, 1'b0);

        // backpressure: ready_out low for 4 cycles while streaming tags 1..5
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            bus.valid_in   = 1'b1;
            bus.tag_in     = 8'(k + 1);
            bus.raw_exp_in = {10'(k), 10'(k * 3), 10'd7, 10'h200, 10'(40 - k)};
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk); #1;
            if (acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'd2);
        chk("bp_ready_in", 64'(bus.ready_in), 64'd0);
        chk("bp_tag_hold", 64'(bus.tag_out), 64'd1);
        bus.ready_out = 1'b1;
        guard = 0;
        while (k < 5 && guard < 50) begin
            bus.valid_in   = 1'b1;
            bus.tag_in     = 8'(k + 1);
            bus.raw_exp_in = {10'(k), 10'(k * 3), 10'd7, 10'h200, 10'(40 - k)};
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        bus.valid_in = 1'b0;
        chk("bp_all_sent", 64'(k), 64'd5);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(q.size()), 64'd0);

        // reset mid-flight with two beats held
        bus.ready_out = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.valid_in   = 1'b1;
            bus.tag_in     = 8'(8'hA0 + c);
            bus.raw_exp_in = {5{10'(c + 9)}};
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        chk("mid_full", 64'(bus.valid_out), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(bus.valid_out), 64'd0);
        chk("mid_rst_payload", 64'(w_obs), 64'd0);
        reset = 1'b1;
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid2", 64'(bus.valid_out), 64'd0);
        send_lat("post_rst", {10'd3, 10'd1, 10'd2, 10'd4, 10'd0},
                 8'h66, 10'd4, 5'b00000, 1'b0);

        // random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            base = int'($urandom % 200) - 100;
            tg   = 8'($urandom);
            bus.valid_in  = ($urandom % 10) < 7;
            bus.ready_out = ($urandom % 10) < 7;
            bus.tag_in    = tg;
            for (int i = 0; i < 5; i++) bus.raw_exp_in[i] = rnd_exp(base);
        end
        @(posedge clk); #1;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_drained", 64'(q.size()), 64'd0);
        chk("final_idle", 64'(bus.valid_out), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
